// File: rtl/run_monitor_if.sv
// Handshake/bus bundle between a run_monitor and whatever drives the
// observed core: run control, retired-instruction stream, dump handshake,
// status flags and counters.
interface run_monitor_if #(
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned CNT_W   = 32
);

   // Control and observation inputs to the monitor
   logic               start;
   logic               instr_valid;
   logic [INSTR_W-1:0] instr;
   logic               dump_ack;

   // Status outputs from the monitor
   logic               dump_req;
   logic               running;
   logic               done;
   logic               timeout;
   logic [CNT_W-1:0]   cycle_count;
   logic [CNT_W-1:0]   instr_count;

   // Side that drives the run and observes the status
   modport master (
      output start,
      output instr_valid,
      output instr,
      output dump_ack,
      input  dump_req,
      input  running,
      input  done,
      input  timeout,
      input  cycle_count,
      input  instr_count
   );

   // The monitor itself
   modport slave (
      input  start,
      input  instr_valid,
      input  instr,
      input  dump_ack,
      output dump_req,
      output running,
      output done,
      output timeout,
      output cycle_count,
      output instr_count
   );

endinterface

// File: rtl/run_monitor.sv
// run_monitor: watches a retired-instruction stream during a run, counts
// cycles and instructions, detects a halt opcode (masked compare) and a
// run-cycle limit, and optionally requests a memory dump after a halt.
//
// Build option: define RUN_MONITOR_DUMP_EN to include the DUMP state and the
// dump_req/dump_ack handshake. Without it a halt goes straight to DONE,
// dump_req is tied low and dump_ack is ignored.
//
// State flags and counters are registered; the flags are decoded from the
// next state so they line up with the state register.
module run_monitor #(
   parameter int unsigned        INSTR_W     = 16,
   parameter logic [INSTR_W-1:0] HALT_OPCODE = INSTR_W'(16'hF000),
   parameter logic [INSTR_W-1:0] HALT_MASK   = '1,
   parameter int unsigned        TIMEOUT     = 1000,
   parameter int unsigned        CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   run_monitor_if.slave      bus
);

   // Counter value on which the last permitted run cycle is spent
   localparam logic [CNT_W-1:0] LP_TOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [INSTR_W-1:0] LP_HALT_CMP = HALT_OPCODE & HALT_MASK;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RUN  = 3'd1,
      ST_DUMP = 3'd2,
      ST_DONE = 3'd3,
      ST_TOUT = 3'd4
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cycle_count;
   logic [CNT_W-1:0] r_instr_count;
   logic             r_running;
   logic             r_done;
   logic             r_timeout;

   state_t           w_state_nxt;
   logic             w_halt_match;
   logic             w_tout_hit;
   logic [CNT_W-1:0] w_cycle_inc;
   logic [CNT_W-1:0] w_instr_inc;

   // Masked halt-opcode compare on a retired instruction
   assign w_halt_match = bus.instr_valid
                         && ((bus.instr & HALT_MASK) == LP_HALT_CMP);

   // Run limit reached on this cycle
   assign w_tout_hit = (r_cycle_count == LP_TOUT_LAST);

   // Saturating increments for both counters
   assign w_cycle_inc = (&r_cycle_count) ? r_cycle_count
                                         : r_cycle_count + CNT_W'(1);
   assign w_instr_inc = (&r_instr_count) ? r_instr_count
                                         : r_instr_count + CNT_W'(1);

   // Next-state decode; a halt beats a timeout in the same cycle, and in
   // DUMP a completed dump beats a timeout in the same cycle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE, ST_TOUT: begin
            if (bus.start) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_halt_match) begin
`ifdef RUN_MONITOR_DUMP_EN
               w_state_nxt = ST_DUMP;
`else
               w_state_nxt = ST_DONE;
`endif
            end else if (w_tout_hit) begin
               w_state_nxt = ST_TOUT;
            end
         end
         ST_DUMP: begin
`ifdef RUN_MONITOR_DUMP_EN
            if (bus.dump_ack) begin
               w_state_nxt = ST_DONE;
            end else if (w_tout_hit) begin
               w_state_nxt = ST_TOUT;
            end
`else
            w_state_nxt = ST_IDLE;
`endif
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

`ifdef RUN_MONITOR_DUMP_EN
   logic r_dump_req;

   // Dump request is high exactly while the state register holds DUMP
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dump_req <= 1'b0;
      end else begin
         r_dump_req <= (w_state_nxt == ST_DUMP);
      end
   end

   assign bus.dump_req = r_dump_req;
`else
   logic w_unused_dump_ack;

   assign w_unused_dump_ack = bus.dump_ack;
   assign bus.dump_req      = 1'b0;
`endif

   // State register, registered status flags and run counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_running     <= 1'b0;
         r_done        <= 1'b0;
         r_timeout     <= 1'b0;
         r_cycle_count <= '0;
         r_instr_count <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_running <= (w_state_nxt == ST_RUN);
         r_done    <= (w_state_nxt == ST_DONE);
         r_timeout <= (w_state_nxt == ST_TOUT);

         case (r_state)
            ST_IDLE, ST_DONE, ST_TOUT: begin
               if (bus.start) begin
                  r_cycle_count <= '0;
                  r_instr_count <= '0;
               end
            end
            ST_RUN: begin
               r_cycle_count <= w_cycle_inc;
               if (bus.instr_valid) begin
                  r_instr_count <= w_instr_inc;
               end
            end
            ST_DUMP: begin
               r_cycle_count <= w_cycle_inc;
            end
            default: begin
               r_cycle_count <= r_cycle_count;
            end
         endcase
      end
   end

   assign bus.running     = r_running;
   assign bus.done        = r_done;
   assign bus.timeout     = r_timeout;
   assign bus.cycle_count = r_cycle_count;
   assign bus.instr_count = r_instr_count;

endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: two instances sharing one stimulus stream
// (A: TIMEOUT=20, HALT_MASK=16'hF000; B: TIMEOUT=10, full mask), directed
// scenarios with literal expectations, then randomized traffic including
// asynchronous resets. A behavioural model per instance predicts outputs.
module tb_run_monitor;

   localparam int unsigned IW     = 16;
   localparam int unsigned CW     = 32;
   localparam int unsigned T_A    = 20;
   localparam int unsigned T_B    = 10;
   localparam logic [15:0] OPC    = 16'hF000;
   localparam logic [15:0] MASK_A = 16'hF000;
   localparam logic [15:0] MASK_B = 16'hFFFF;
   localparam longint unsigned CMAX = (64'd1 << CW) - 64'd1;

`ifdef RUN_MONITOR_DUMP_EN
   localparam bit DUMP_EN = 1'b1;
`else
   localparam bit DUMP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        iv;
   logic [15:0] instr;
   logic        ack;
   bit          cmp_en = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   run_monitor_if #(.INSTR_W(IW), .CNT_W(CW)) if_a ();
   run_monitor_if #(.INSTR_W(IW), .CNT_W(CW)) if_b ();

   assign if_a.start       = start;
   assign if_a.instr_valid = iv;
   assign if_a.instr       = instr;
   assign if_a.dump_ack    = ack;
   assign if_b.start       = start;
   assign if_b.instr_valid = iv;
   assign if_b.instr       = instr;
   assign if_b.dump_ack    = ack;

   run_monitor #(.INSTR_W(IW), .HALT_OPCODE(OPC), .HALT_MASK(MASK_A),
                 .TIMEOUT(T_A), .CNT_W(CW))
      dut_a (.clk(clk), .rst(rst), .bus(if_a));

   run_monitor #(.INSTR_W(IW), .HALT_OPCODE(OPC), .HALT_MASK(MASK_B),
                 .TIMEOUT(T_B), .CNT_W(CW))
      dut_b (.clk(clk), .rst(rst), .bus(if_b));

   // ---------------- behavioural model ----------------
   typedef enum int {P_IDLE, P_RUN, P_DUMP, P_DONE, P_TOUT} phase_t;
   typedef struct {
      phase_t          ph;
      longint unsigned cc;
      longint unsigned ic;
   } mstate_t;

   mstate_t m [2];

   function automatic longint unsigned sat1(input longint unsigned v);
      return (v == CMAX) ? v : v + 64'd1;
   endfunction

   // One clock of the run rules for instance k, using the current inputs
   function automatic mstate_t mdl_step(input int k, input mstate_t s);
      mstate_t         n    = s;
      logic [15:0]     mk   = (k == 0) ? MASK_A : MASK_B;
      longint unsigned lim  = (k == 0) ? 64'(T_A) : 64'(T_B);
      bit              halt = iv && ((instr & mk) == (OPC & mk));
      bit              last = (s.cc == lim - 64'd1);
      if (s.ph == P_IDLE || s.ph == P_DONE || s.ph == P_TOUT) begin
         if (start) begin
            n.ph = P_RUN;
            n.cc = 0;
            n.ic = 0;
         end
      end else if (s.ph == P_RUN) begin
         n.cc = sat1(s.cc);
         if (iv) n.ic = sat1(s.ic);
         if (halt)      n.ph = DUMP_EN ? P_DUMP : P_DONE;
         else if (last) n.ph = P_TOUT;
      end else begin
         n.cc = sat1(s.cc);
         if (ack)       n.ph = P_DONE;
         else if (last) n.ph = P_TOUT;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst) m[k] <= '{P_IDLE, 64'd0, 64'd0};
         else      m[k] <= mdl_step(k, m[k]);
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_dut(input string tag, input int k,
                          input logic run, input logic dreq,
                          input logic dn, input logic to,
                          input logic [CW-1:0] cc, input logic [CW-1:0] ic);
      chk({tag, ".running"},     64'(run),  64'(m[k].ph == P_RUN));
      chk({tag, ".dump_req"},    64'(dreq), 64'(m[k].ph == P_DUMP));
      chk({tag, ".done"},        64'(dn),   64'(m[k].ph == P_DONE));
      chk({tag, ".timeout"},     64'(to),   64'(m[k].ph == P_TOUT));
      chk({tag, ".cycle_count"}, 64'(cc),   m[k].cc);
      chk({tag, ".instr_count"}, 64'(ic),   m[k].ic);
      chk({tag, ".done_and_timeout"}, 64'(dn & to), 64'd0);
   endtask

   // Per-cycle comparison against the model, away from the rising edge
   always @(negedge clk) begin
      if (cmp_en) begin
         cmp_dut("a", 0, if_a.running, if_a.dump_req, if_a.done, if_a.timeout,
                 if_a.cycle_count, if_a.instr_count);
         cmp_dut("b", 1, if_b.running, if_b.dump_req, if_b.done, if_b.timeout,
                 if_b.cycle_count, if_b.instr_count);
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".a.running"},  64'(if_a.running),     64'd0);
      chk({tag, ".a.dump_req"}, 64'(if_a.dump_req),    64'd0);
      chk({tag, ".a.done"},     64'(if_a.done),        64'd0);
      chk({tag, ".a.timeout"},  64'(if_a.timeout),     64'd0);
      chk({tag, ".a.cc"},       64'(if_a.cycle_count), 64'd0);
      chk({tag, ".a.ic"},       64'(if_a.instr_count), 64'd0);
      chk({tag, ".b.running"},  64'(if_b.running),     64'd0);
      chk({tag, ".b.cc"},       64'(if_b.cycle_count), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst   = 1'b0;
      start = 1'b0;
      iv    = 1'b0;
      instr = '0;
      ack   = 1'b0;
      cyc();
      cyc();
      cmp_en = 1'b1;
      chk_all_zero("reset");
      rst = 1'b1;

      // Five ordinary instructions then a halt; dump acknowledged later
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("s1.running", 64'(if_a.running), 64'd1);
      chk("s1.cc0",     64'(if_a.cycle_count), 64'd0);
      for (int i = 0; i < 5; i++) begin
         iv    = 1'b1;
         instr = 16'h1230 + 16'(i);
         cyc();
      end
      instr = 16'hF000;
      cyc();
      iv = 1'b0;
      chk("s1.ic_at_halt",   64'(if_a.instr_count), 64'd6);
      chk("s1.dreq_at_halt", 64'(if_a.dump_req),    64'(DUMP_EN));
      chk("s1.done_at_halt", 64'(if_a.done),        64'(!DUMP_EN));
      cyc();
      cyc();
      ack = 1'b1;
      cyc();
      ack = 1'b0;
      chk("s1.done",   64'(if_a.done),        64'd1);
      chk("s1.dreq",   64'(if_a.dump_req),    64'd0);
      chk("s1.tout",   64'(if_a.timeout),     64'd0);
      chk("s1.cc",     64'(if_a.cycle_count), DUMP_EN ? 64'd9 : 64'd6);
      ack = 1'b1;
      cyc();
      ack = 1'b0;
      cyc();
      chk("s1.cc_frozen", 64'(if_a.cycle_count), DUMP_EN ? 64'd9 : 64'd6);
      chk("s1.ic_frozen", 64'(if_a.instr_count), 64'd6);

      // No halt: run limit expires
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (19) cyc();
      chk("s2.still_run", 64'(if_a.running),     64'd1);
      chk("s2.cc19",      64'(if_a.cycle_count), 64'd19);
      cyc();
      chk("s2.timeout", 64'(if_a.timeout),     64'd1);
      chk("s2.cc",      64'(if_a.cycle_count), 64'd20);
      chk("s2.done",    64'(if_a.done),        64'd0);
      chk("s2.b_tout",  64'(if_b.timeout),     64'd1);
      chk("s2.b_cc",    64'(if_b.cycle_count), 64'd10);

      // Halt on the last permitted cycle of instance B
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (9) cyc();
      iv    = 1'b1;
      instr = 16'hF000;
      cyc();
      iv = 1'b0;
      chk("s3.b_tout", 64'(if_b.timeout),     64'd0);
      chk("s3.b_dreq", 64'(if_b.dump_req),    64'(DUMP_EN));
      chk("s3.b_done", 64'(if_b.done),        64'(!DUMP_EN));
      chk("s3.b_cc",   64'(if_b.cycle_count), 64'd10);
      chk("s3.b_ic",   64'(if_b.instr_count), 64'd1);
      ack = 1'b1;
      cyc();
      ack = 1'b0;
      chk("s3.b_done2", 64'(if_b.done),        64'd1);
      chk("s3.b_cc2",   64'(if_b.cycle_count), DUMP_EN ? 64'd11 : 64'd10);

      // Masked halt pattern, then asynchronous reset mid-run
      start = 1'b1;
      cyc();
      start = 1'b0;
      iv    = 1'b1;
      instr = 16'hF123;
      cyc();
      iv = 1'b0;
      chk("s4.a_dreq",  64'(if_a.dump_req), 64'(DUMP_EN));
      chk("s4.a_done",  64'(if_a.done),     64'(!DUMP_EN));
      chk("s4.b_run",   64'(if_b.running),  64'd1);
      #2;
      rst = 1'b0;
      #1;
      chk_all_zero("async_rst");
      cyc();
      rst = 1'b1;
      cyc();
      chk("s4.idle_after_rst", 64'(if_a.running), 64'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int r;
         start = ($urandom_range(0, 19) == 0);
         iv    = 1'($urandom_range(0, 1));
         r     = int'($urandom_range(0, 9));
         if (r == 0)      instr = 16'hF000;
         else if (r == 1) instr = {4'hF, 12'($urandom)};
         else             instr = 16'($urandom);
         ack = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 299) == 0) begin
            #3;
            rst = 1'b0;
            #1;
            chk_all_zero("rand_rst");
            cyc();
            rst = 1'b1;
         end else begin
            cyc();
         end
      end

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 SHALL have parameter INSTR_W, default 16: width of the observed instruction word.
REQ-002 SHALL have parameter HALT_OPCODE, default 16'hF000 (INSTR_W bits): halt pattern.
REQ-003 SHALL have parameter HALT_MASK, default all ones (INSTR_W bits): bits compared against HALT_OPCODE.
REQ-004 SHALL have parameter TIMEOUT, default 1000: run-cycle limit, legal range 1..2^CNT_W-1.
REQ-005 SHALL have parameter CNT_W, default 32: counter width.
REQ-006 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  input  1  begin or restart a run.
REQ-009 SHALL have port instr_valid  input  1  instr is a retired instruction this cycle.
REQ-010 SHALL have port instr  input  INSTR_W  observed instruction.
REQ-011 SHALL have port dump_ack  input  1  memory dump complete.
REQ-012 SHALL have port dump_req  output  1  request memory dump.
REQ-013 SHALL have port running  output  1  state is RUN.
REQ-014 SHALL have port done  output  1  halted normally; sticky.
REQ-015 SHALL have port timeout  output  1  run limit expired; sticky.
REQ-016 SHALL have port cycle_count  output  CNT_W  cycles spent in RUN/DUMP.
REQ-017 SHALL have port instr_count  output  CNT_W  valid instructions seen in RUN.

Function
REQ-018 SHALL implement states IDLE, RUN, DUMP, DONE, TOUT; outputs registered, decoded from state.
REQ-019 IDLE/DONE/TOUT: start=1 SHALL clear both counters and enter RUN next edge.
REQ-020 RUN/DUMP: start SHALL be ignored.
REQ-021 RUN/DUMP: cycle_count SHALL increment by 1 each cycle, saturating at all ones.
REQ-022 RUN: instr_valid=1 SHALL increment instr_count (saturating), including the halt instruction itself.
REQ-023 Halt match SHALL be instr_valid && ((instr & HALT_MASK) == (HALT_OPCODE & HALT_MASK)).
REQ-024 RUN with halt match SHALL enter DUMP next edge; dump_req=1 from that cycle.
REQ-025 RUN or DUMP with cycle_count == TIMEOUT-1 and no halt match SHALL enter TOUT.
REQ-026 Halt match and timeout in the same cycle: halt SHALL win.
REQ-027 DUMP SHALL hold dump_req=1 until dump_ack=1 is sampled, then enter DONE; dump_req=0 in DONE.
REQ-028 dump_ack outside DUMP SHALL be ignored.
REQ-029 Timeout in DUMP SHALL enter TOUT and drop dump_req.
REQ-030 DONE and TOUT SHALL hold counters frozen until start.
REQ-031 done and timeout SHALL never both be 1.

Reset
REQ-032 rst=0 SHALL immediately force IDLE, dump_req=0, running=0, done=0, timeout=0, counters=0, regardless of clock.
REQ-033 Reset mid-run or mid-DUMP SHALL abandon the run with no dump_req glitch after assertion.
REQ-034 First edge after rst release SHALL be evaluated from IDLE.

Configuration
REQ-035 Macro RUN_MONITOR_DUMP_EN defined: DUMP state and dump handshake present as above.
REQ-036 Macro RUN_MONITOR_DUMP_EN undefined: halt match SHALL go RUN->DONE directly, dump_req tied 0, dump_ack unused.

Verification
REQ-037 Reset, start, 5 valid non-halt instrs then 16'hF000 at cycle 7 -> dump_req at cycle 8, instr_count=6.
REQ-038 dump_ack 3 cycles after dump_req -> DONE, done=1, dump_req=0, cycle_count frozen.
REQ-039 TIMEOUT=20, no halt -> timeout=1 after 20 RUN cycles, cycle_count=20, done=0.
REQ-040 TIMEOUT=10, halt on cycle where cycle_count=9 -> DUMP, not TOUT.
REQ-041 HALT_MASK=16'hF000, instr 16'hF123 -> halt detected; rst=0 during DUMP -> all outputs 0 asynchronously.
REQ-042 Build without RUN_MONITOR_DUMP_EN, halt -> done next cycle, dump_req never 1.
